demux1_2_buf: RTL and testbench

//   Buffered 1-to-2 demultiplexer: the inverse of the 2:1 datapath mux. Accepts one 32-bit

---
 rtl/demux1_2_buf_pkg.sv | 16 +
 rtl/demux_fifo.sv | 69 ++++++
 rtl/demux1_2_buf.sv | 71 +++++++
 tb/tb_demux1_2_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux1_2_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
// Select encoding and default sizing live here so the top and the bench agree on them.
package demux1_2_buf_pkg;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_DEPTH = 2;

    typedef enum logic {
        DEST_A = DEMUX_SEL_A,
        DEST_B = DEMUX_SEL_B
    } dest_e;

endpackage : demux1_2_buf_pkg

// File: rtl/demux_fifo.sv
// Synchronous first-word-fall-through FIFO used once per demux destination.
// Head is a plain mux from the array; the data output is forced to zero while empty.
module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop_ready,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_empty   = (r_count == '0);
        o_full    = (r_count == CW'(DEPTH));
        o_valid   = ~w_empty & ~reset;
        o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
        o_count   = r_count;
        w_do_push = i_push & ~o_full;
        w_do_pop  = o_valid & i_pop_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : demux_fifo

// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into FIFO A or B by in_sel,
// so a stalled consumer on one side never blocks traffic to the other.
module demux1_2_buf
    import demux1_2_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sel,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         outa_valid,
    input  logic                         outa_ready,
    output logic [WIDTH-1:0]             outa_data,
    output logic [$clog2(DEPTH+1)-1:0]   outa_count,
    output logic                         outb_valid,
    input  logic                         outb_ready,
    output logic [WIDTH-1:0]             outb_data,
    output logic [$clog2(DEPTH+1)-1:0]   outb_count
);

    dest_e w_dest;
    logic  w_full_a;
    logic  w_full_b;
    logic  w_accept;
    logic  w_push_a;
    logic  w_push_b;

    // Ready looks only at the selected FIFO's full flag, never at same-cycle pops.
    always_comb begin
        w_dest   = dest_e'(in_sel);
        in_ready = (w_dest == DEST_B) ? ~w_full_b : ~w_full_a;
        w_accept = in_valid & in_ready;
        w_push_a = w_accept & (w_dest == DEST_A);
        w_push_b = w_accept & (w_dest == DEST_B);
    end

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push_a),
        .i_push_data (in_data),
        .i_pop_ready (outa_ready),
        .o_valid     (outa_valid),
        .o_data      (outa_data),
        .o_full      (w_full_a),
        .o_count     (outa_count)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push_b),
        .i_push_data (in_data),
        .i_pop_ready (outb_ready),
        .o_valid     (outb_valid),
        .o_data      (outb_data),
        .o_full      (w_full_b),
        .o_count     (outb_count)
    );

endmodule : demux1_2_buf

// File: tb/tb_demux1_2_buf.sv
// Scoreboard bench for demux1_2_buf: per-port expected queues are filled on accepted
// pushes and drained/compared when the consumer pops.
module tb_demux1_2_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             outa_valid, outb_valid;
    logic             outa_ready, outb_ready;
    logic [WIDTH-1:0] outa_data, outb_data;
    logic [CW-1:0]    outa_count, outb_count;

    demux1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .outa_valid (outa_valid),
        .outa_ready (outa_ready),
        .outa_data  (outa_data),
        .outa_count (outa_count),
        .outb_valid (outb_valid),
        .outb_ready (outb_ready),
        .outb_data  (outb_data),
        .outb_count (outb_count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  known    = 1'b0;
    bit  last_acc;
    int  n_pop_a  = 0;
    int  n_pop_b  = 0;
    bit  track_seq = 1'b0;
    logic [WIDTH-1:0] seq_exp;
    logic [WIDTH-1:0] last_pop_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs at negedge against the model, then advance the model at posedge.
    task automatic step();
        bit exp_ready, pop_a, pop_b;
        @(negedge clk);
        exp_ready = in_sel ? (q_b.size() < DEPTH) : (q_a.size() < DEPTH);
        if (known) begin
            check("in_ready", in_ready, exp_ready);
            check("outa_valid", outa_valid, !reset && q_a.size() != 0);
            check("outb_valid", outb_valid, !reset && q_b.size() != 0);
            check("outa_data", outa_data, (!reset && q_a.size() != 0) ? q_a[0] : '0);
            check("outb_data", outb_data, (!reset && q_b.size() != 0) ? q_b[0] : '0);
            check("outa_count", outa_count, q_a.size());
            check("outb_count", outb_count, q_b.size());
        end
        last_acc = known && !reset && in_valid && exp_ready;
        pop_a    = known && !reset && outa_ready && q_a.size() != 0;
        pop_b    = known && !reset && outb_ready && q_b.size() != 0;
        if (pop_a) begin
            check("pop_a", outa_data, q_a.pop_front());
            if (track_seq) begin
                check("order_a", outa_data, seq_exp);
                seq_exp++;
            end
            n_pop_a++;
        end
        if (pop_b) begin
            check("pop_b", outb_data, q_b.pop_front());
            last_pop_b = outb_data;
            n_pop_b++;
        end
        @(posedge clk);
        if (reset) begin
            q_a.delete();
            q_b.delete();
            known = 1'b1;
        end else if (last_acc) begin
            if (in_sel) q_b.push_back(in_data);
            else        q_a.push_back(in_data);
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic drain();
        int cyc;
        drive(1'b0, 1'b0, '0);
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        cyc = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        check("drain_done", q_a.size() + q_b.size(), 0);
        outa_ready = 1'b0;
        outb_ready = 1'b0;
    endtask

    initial begin
        int cyc, k;
        bit tog;
        reset      = 1'b1;
        outa_ready = 1'b0;
        outb_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0011);
        #1;

        // Reset held two cycles with a word offered: nothing may be accepted.
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        step();
        check("rst_count_a", outa_count, 0);
        check("rst_ready", in_ready, 1);

        // Steering: one word to each port, both consumers stalled.
        drive(1'b1, 1'b0, 32'hA5A5_0001);
        step();
        check("steer_a_data", outa_data, 32'hA5A5_0001);
        check("steer_a_count", outa_count, 1);
        drive(1'b1, 1'b1, 32'h5A5A_0002);
        step();
        check("steer_b_data", outb_data, 32'h5A5A_0002);
        check("steer_b_count", outb_count, 1);

        // Fill A, third push to A stalls, B still accepts.
        drive(1'b1, 1'b0, 32'h0000_0003);
        step();
        drive(1'b1, 1'b0, 32'h0000_0004);
        step();
        check("stall_acc", last_acc, 0);
        check("stall_ready", in_ready, 0);
        check("stall_count", outa_count, 2);
        drive(1'b1, 1'b1, 32'h0000_00BB);
        step();
        check("iso_b_acc", last_acc, 1);
        check("iso_b_count", outb_count, 2);

        // A full, pop and push offered together: push waits one cycle.
        drive(1'b1, 1'b0, 32'h0000_00CC);
        outa_ready = 1'b1;
        step();
        check("fullpop_acc", last_acc, 0);
        outa_ready = 1'b0;
        step();
        check("fullpop_acc2", last_acc, 1);
        check("fullpop_count", outa_count, 2);
        drain();

        // Stream 0x1..0x10 into A with a toggling consumer; pointers wrap many times.
        track_seq = 1'b1;
        seq_exp   = 32'h1;
        n_pop_a   = 0;
        k   = 1;
        tog = 1'b1;
        cyc = 0;
        while ((k <= 16 || q_a.size() != 0) && cyc < 200) begin
            drive(k <= 16, 1'b0, WIDTH'(k));
            outa_ready = tog;
            tog = ~tog;
            step();
            if (last_acc) k++;
            cyc++;
        end
        track_seq = 1'b0;
        check("wrap_budget", cyc < 200, 1);
        check("wrap_pops", n_pop_a, 16);
        check("wrap_last", seq_exp, 32'h11);
        outa_ready = 1'b0;

        // Mid-operation reset with A=2, B=1 and a push in flight.
        drive(1'b1, 1'b0, 32'h0000_0021);
        step();
        drive(1'b1, 1'b0, 32'h0000_0022);
        step();
        drive(1'b1, 1'b1, 32'h0000_0023);
        step();
        check("pre_rst_a", outa_count, 2);
        check("pre_rst_b", outb_count, 1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0024);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        step();
        check("mid_rst_va", outa_valid, 0);
        check("mid_rst_vb", outb_valid, 0);
        check("mid_rst_cb", outb_count, 0);
        n_pop_b = 0;
        drive(1'b1, 1'b1, 32'hDEAD_BEEF);
        outb_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, '0);
        step();
        step();
        check("post_rst_pops_b", n_pop_b, 1);
        check("post_rst_word", last_pop_b, 32'hDEAD_BEEF);
        check("post_rst_count_a", outa_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_demux1_2_buf
